// File: rtl/coreport_pkg.sv
// Shared types and constants for the CorePort Wishbone initiator.
package coreport_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BUS,
        ST_GAP,
        ST_LAG,
        ST_RESP
    } state_e;

    localparam logic [1:0] RSP_OK      = 2'b00;
    localparam logic [1:0] RSP_ERR     = 2'b01;
    localparam logic [1:0] RSP_TIMEOUT = 2'b10;
    localparam logic [1:0] RSP_RETRY   = 2'b11;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/coreport_wbm.sv
// Single-outstanding Wishbone classic initiator: one command in, one bus
// cycle (with bounded retries and timeout), one response out.
module coreport_wbm
    import coreport_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned RDATA_LAG = 1
) (
    input  logic             wb_clk,
    input  logic             wb_rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [31:0]      cmd_adr,
    input  logic [WIDTH-1:0] cmd_dat,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_dat,
    output logic [1:0]       rsp_status,
    output logic [31:0]      wb_adr_o,
    output logic [WIDTH-1:0] wb_dat_o,
    output logic             wb_we_o,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic [2:0]       wb_cti_o,
    output logic [1:0]       wb_bte_o,
    input  logic [WIDTH-1:0] wb_dat_i,
    input  logic             wb_ack_i,
    input  logic             wb_err_i,
    input  logic             wb_rty_i
);

    // Counters keep at least one bit so a zero parameter still elaborates.
    localparam int unsigned TW = (TIMEOUT > 0)   ? $clog2(TIMEOUT + 1)   : 1;
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);
    localparam logic [RW-1:0] RTY_LIMIT = RW'(MAX_RETRY);

    state_e            state_q;
    logic [TW-1:0]     tmo_q;
    logic [RW-1:0]     rty_q;
    logic [31:0]       adr_q;
    logic [WIDTH-1:0]  dat_q;
    logic              we_q;
    logic              cyc_q;
    logic              rsp_valid_q;
    logic [WIDTH-1:0]  rsp_dat_q;
    logic [1:0]        rsp_status_q;

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_q      <= ST_IDLE;
            tmo_q        <= '0;
            rty_q        <= '0;
            adr_q        <= '0;
            dat_q        <= '0;
            we_q         <= 1'b0;
            cyc_q        <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_dat_q    <= '0;
            rsp_status_q <= RSP_OK;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        adr_q   <= cmd_adr;
                        dat_q   <= cmd_dat;
                        we_q    <= cmd_we;
                        tmo_q   <= '0;
                        rty_q   <= '0;
                        cyc_q   <= 1'b1;
                        state_q <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (wb_err_i) begin
                        cyc_q        <= 1'b0;
                        rsp_dat_q    <= '0;
                        rsp_status_q <= RSP_ERR;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= ST_RESP;
                    end else if (wb_rty_i) begin
                        cyc_q <= 1'b0;
                        if (rty_q == RTY_LIMIT) begin
                            rsp_dat_q    <= '0;
                            rsp_status_q <= RSP_RETRY;
                            rsp_valid_q  <= 1'b1;
                            state_q      <= ST_RESP;
                        end else begin
                            rty_q   <= rty_q + RW'(1);
                            tmo_q   <= '0;
                            state_q <= ST_GAP;
                        end
                    end else if (wb_ack_i) begin
                        cyc_q <= 1'b0;
                        if (we_q || RDATA_LAG == 0) begin
                            rsp_dat_q    <= we_q ? '0 : wb_dat_i;
                            rsp_status_q <= RSP_OK;
                            rsp_valid_q  <= 1'b1;
                            state_q      <= ST_RESP;
                        end else begin
                            state_q <= ST_LAG;
                        end
                    end else if (TIMEOUT != 0 && tmo_q == TMO_LIMIT) begin
                        cyc_q        <= 1'b0;
                        rsp_dat_q    <= '0;
                        rsp_status_q <= RSP_TIMEOUT;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= ST_RESP;
                    end else if (tmo_q != '1) begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                ST_GAP: begin
                    cyc_q   <= 1'b1;
                    state_q <= ST_BUS;
                end
                ST_LAG: begin
                    rsp_dat_q    <= wb_dat_i;
                    rsp_status_q <= RSP_OK;
                    rsp_valid_q  <= 1'b1;
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    cyc_q       <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = (state_q == ST_IDLE);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_dat    = rsp_dat_q;
    assign rsp_status = rsp_status_q;
    assign wb_adr_o   = adr_q;
    assign wb_dat_o   = dat_q;
    assign wb_we_o    = we_q;
    assign wb_cyc_o   = cyc_q;
    assign wb_stb_o   = cyc_q;
    assign wb_cti_o   = CTI_CLASSIC;
    assign wb_bte_o   = BTE_LINEAR;

endmodule

// File: tb/tb_coreport_wbm.sv
// Directed bench for coreport_wbm against a scripted Wishbone responder.
module tb_coreport_wbm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [7:0]  cmd_dat = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [7:0]  rsp_dat;
    logic [1:0]  rsp_status;
    logic [31:0] wb_adr_o;
    logic [7:0]  wb_dat_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic [7:0]  wb_dat_i;
    logic        wb_ack_i, wb_err_i, wb_rty_i;

    always #5 clk = ~clk;

    coreport_wbm #(
        .WIDTH(8),
        .TIMEOUT(8),
        .MAX_RETRY(3),
        .RDATA_LAG(1)
    ) dut (
        .wb_clk(clk), .wb_rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_dat(rsp_dat), .rsp_status(rsp_status),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
        .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
    );

    // Responder: mode 0 = ack after `waits` cycles (rty for the first rty_n
    // attempts), mode 1 = never terminates, mode 2 = err and ack together.
    int        mode = 0;
    int        waits = 0;
    int        rty_n = 0;
    int        wcnt = 0;
    int        att = 0;
    logic [7:0] mem [0:15];
    logic [7:0] rdata_q = '0;
    logic       sel;

    assign sel      = wb_cyc_o && wb_stb_o;
    assign wb_rty_i = sel && mode == 0 && att < rty_n && wcnt == waits;
    assign wb_ack_i = sel && ((mode == 0 && att >= rty_n && wcnt == waits) || mode == 2);
    assign wb_err_i = sel && mode == 2;
    assign wb_dat_i = rdata_q;

    initial for (int i = 0; i < 16; i++) mem[i] = '0;

    always @(posedge clk) begin
        wcnt <= sel ? wcnt + 1 : 0;
        if (cmd_valid && cmd_ready) att <= 0;
        else if (wb_rty_i) att <= att + 1;
        if (wb_ack_i && wb_we_o) mem[wb_adr_o[5:2]] <= wb_dat_o;
        if (wb_ack_i && !wb_we_o) rdata_q <= mem[wb_adr_o[5:2]];
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [7:0]  dat;
        int          mode;
        int          waits;
        int          rty_n;
        logic [1:0]  st;
        logic [7:0]  rd;
        int          cyc;
        int          att;
        int          lat;
    } vec_t;

    vec_t vecs [10];

    task automatic run_vec(input int idx, input vec_t v);
        int cyc_n, att_n, lat;
        logic prev;
        @(negedge clk);
        mode = v.mode; waits = v.waits; rty_n = v.rty_n;
        cmd_we = v.we; cmd_adr = v.adr; cmd_dat = v.dat; cmd_valid = 1'b1;
        chk($sformatf("v%0d_ready_before", idx), 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cyc_n = 0; att_n = 0; lat = 0; prev = 1'b0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge clk);
            if (wb_cyc_o) cyc_n++;
            if (wb_cyc_o && !prev) att_n++;
            prev = wb_cyc_o;
            if (rsp_valid) lat = k;
        end
        chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
        chk($sformatf("v%0d_status", idx), 32'(rsp_status), 32'(v.st));
        chk($sformatf("v%0d_rdata", idx), 32'(rsp_dat), 32'(v.rd));
        chk($sformatf("v%0d_cyc_cycles", idx), 32'(cyc_n), 32'(v.cyc));
        chk($sformatf("v%0d_attempts", idx), 32'(att_n), 32'(v.att));
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_ready_after", idx), 32'(cmd_ready), 32'd1);
        chk($sformatf("v%0d_valid_after", idx), 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        //            we    adr    dat    mode w  rty st     rd     cyc att lat
        vecs[0] = '{1'b1, 32'h04, 8'h5A, 0, 0, 0, 2'b00, 8'h00, 1, 1, 2};
        vecs[1] = '{1'b0, 32'h04, 8'h00, 0, 0, 0, 2'b00, 8'h5A, 1, 1, 3};
        vecs[2] = '{1'b1, 32'h00, 8'hC3, 0, 0, 0, 2'b00, 8'h00, 1, 1, 2};
        vecs[3] = '{1'b0, 32'h00, 8'h00, 0, 3, 0, 2'b00, 8'hC3, 4, 1, 6};
        vecs[4] = '{1'b0, 32'h08, 8'h00, 0, 0, 9, 2'b11, 8'h00, 4, 4, 8};
        vecs[5] = '{1'b0, 32'h04, 8'h00, 1, 0, 0, 2'b10, 8'h00, 9, 1, 10};
        vecs[6] = '{1'b0, 32'h04, 8'h00, 2, 0, 0, 2'b01, 8'h00, 1, 1, 2};
        vecs[7] = '{1'b0, 32'h04, 8'h00, 0, 1, 2, 2'b00, 8'h5A, 6, 3, 10};
        vecs[8] = '{1'b1, 32'h0C, 8'h77, 2, 0, 0, 2'b01, 8'h00, 1, 1, 2};
        vecs[9] = '{1'b1, 32'h08, 8'hA5, 0, 2, 0, 2'b00, 8'h00, 3, 1, 4};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
        chk("rst_stb", 32'(wb_stb_o), 32'd0);
        chk("rst_adr", wb_adr_o, 32'd0);
        chk("rst_rsp_dat", 32'(rsp_dat), 32'd0);
        chk("rst_rsp_status", 32'(rsp_status), 32'd0);
        chk("cti_bte", {27'd0, wb_cti_o, wb_bte_o}, 32'd0);

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Back-pressure: response must stay put while rsp_ready is low.
        begin
            int seen;
            @(negedge clk);
            mode = 0; waits = 0; rty_n = 0;
            cmd_we = 1'b0; cmd_adr = 32'h04; cmd_valid = 1'b1;
            @(posedge clk);
            #1 cmd_valid = 1'b0;
            seen = 0;
            for (int k = 0; k < 20 && seen == 0; k++) begin
                @(negedge clk);
                if (rsp_valid) seen = 1;
            end
            chk("bp_rsp_seen", 32'(seen), 32'd1);
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                chk("bp_valid", 32'(rsp_valid), 32'd1);
                chk("bp_dat", 32'(rsp_dat), 32'h5A);
                chk("bp_status", 32'(rsp_status), 32'd0);
                chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            end
            rsp_ready = 1'b1;
            @(posedge clk);
            #1 rsp_ready = 1'b0;
            @(negedge clk);
            chk("bp_ready_after", 32'(cmd_ready), 32'd1);
        end

        // Reset during BUS: cyc/stb drop without waiting for a clock edge.
        begin
            int seen;
            @(negedge clk);
            mode = 1;
            cmd_we = 1'b1; cmd_adr = 32'h10; cmd_dat = 8'h3C; cmd_valid = 1'b1;
            @(posedge clk);
            #1 cmd_valid = 1'b0;
            repeat (3) @(negedge clk);
            chk("mid_cyc_before", 32'(wb_cyc_o), 32'd1);
            #2 rst = 1'b1;
            #1;
            chk("mid_cyc_after_rst", 32'(wb_cyc_o), 32'd0);
            chk("mid_stb_after_rst", 32'(wb_stb_o), 32'd0);
            chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
            mode = 0;
            @(negedge clk);
            rst = 1'b0;
            seen = 0;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                if (rsp_valid || wb_cyc_o) seen = 1;
            end
            chk("mid_no_response", 32'(seen), 32'd0);
            chk("mid_cmd_ready", 32'(cmd_ready), 32'd1);
            chk("mid_adr_cleared", wb_adr_o, 32'd0);
        end

        run_vec(10, vecs[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

endmodule
